// File: rtl/opstack_pkg.sv
// Shared types for the operand-stack responder: FSM state encoding and the captured request.
package opstack_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRdw,
    StResp
  } state_e;

  typedef struct packed {
    logic              push;
    logic [WORD_W-1:0] data;
  } req_t;

endpackage

// File: rtl/opstack_ram.sv
// Single-port synchronous RAM with a registered read port, written to map onto block RAM.
module opstack_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/opstack_responder.sv
// Operand-stack responder: services push/pop requests on a trigger edge, tracks the stack pointer
// and sticky overflow/underflow flags, and always completes with a one-cycle done pulse.
module opstack_responder
  import opstack_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             trigger,
  input  logic [WIDTH-1:0] write_value,
  output logic [WIDTH-1:0] read_value,
  output logic             done_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    sp_q, sp_d, sp_m1;
  req_t             req_q, req_d;
  logic [WIDTH-1:0] read_value_q, read_value_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             trigger_q;
  logic             start;

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_rdata;

  assign start = trigger & ~trigger_q;
  assign sp_m1 = sp_q - CW'(1);

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    req_d        = req_q;
    read_value_d = read_value_q;
    // A new error in the same cycle as clear_err overrides the clear below.
    overflow_d   = overflow_q & ~clear_err;
    underflow_d  = underflow_q & ~clear_err;
    ram_we       = 1'b0;
    ram_addr     = sp_q[AW-1:0];
    done_out     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          req_d.push = push;
          req_d.data = write_value;
          state_d    = push ? StWr : StRd;
        end
      end
      StWr: begin
        if (sp_q < CW'(DEPTH)) begin
          ram_we = req_q.push;
          sp_d   = sp_q + CW'(1);
        end else begin
          overflow_d = 1'b1;
        end
        state_d = StResp;
      end
      StRd: begin
        if (sp_q != '0) begin
          ram_addr = sp_m1[AW-1:0];
          sp_d     = sp_m1;
          state_d  = StRdw;
        end else begin
          underflow_d  = 1'b1;
          read_value_d = '0;
          state_d      = StResp;
        end
      end
      StRdw: begin
        read_value_d = ram_rdata;
        state_d      = StResp;
      end
      StResp: begin
        done_out = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sp_q         <= '0;
      req_q        <= '0;
      read_value_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      trigger_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      req_q        <= req_d;
      read_value_q <= read_value_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      trigger_q    <= trigger;
    end
  end

  opstack_ram #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(req_q.data),
    .rdata_o(ram_rdata)
  );

  assign read_value = read_value_q;
  assign count      = sp_q;
  assign full       = (sp_q == CW'(DEPTH));
  assign empty      = (sp_q == '0);
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_opstack_responder.sv
// Directed bench for opstack_responder with a 4-entry stack so overflow is reachable quickly.
module tb_opstack_responder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push;
  logic          trigger;
  logic [31:0]   write_value;
  logic [31:0]   read_value;
  logic          done_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
  logic          clear_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  opstack_responder #(
    .DEPTH(DEPTH),
    .WIDTH(32),
    .CW   (CW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .trigger    (trigger),
    .write_value(write_value),
    .read_value (read_value),
    .done_out   (done_out),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .clear_err  (clear_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request and checks the number of cycles until done_out, then that it is one cycle.
  task automatic do_req(input logic p, input logic [31:0] d, input int exp_lat, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    push        = p;
    write_value = d;
    trigger     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      trigger = 1'b0;
      if (done_out) begin
        lat = i;
        break;
      end
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    check_eq({tag, "_done_width"}, {31'd0, done_out}, 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  int ndone;

  initial begin
    rst_n       = 1'b0;
    push        = 1'b0;
    trigger     = 1'b0;
    write_value = '0;
    clear_err   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_count", {29'd0, count}, 32'd0);
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_done", {31'd0, done_out}, 32'd0);
    check_eq("rst_rdval", read_value, 32'd0);
    check_eq("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 32'h1111_1111, 2, "push1");
    do_req(1'b1, 32'h2222_2222, 2, "push2");
    do_req(1'b1, 32'h3333_3333, 2, "push3");
    check_eq("push3_count", {29'd0, count}, 32'd3);
    check_eq("push3_empty", {31'd0, empty}, 32'd0);
    check_eq("push_keeps_rdval", read_value, 32'd0);

    do_req(1'b0, '0, 3, "pop1");
    check_eq("pop1_val", read_value, 32'h3333_3333);
    do_req(1'b0, '0, 3, "pop2");
    check_eq("pop2_val", read_value, 32'h2222_2222);
    do_req(1'b0, '0, 3, "pop3");
    check_eq("pop3_val", read_value, 32'h1111_1111);
    check_eq("pop3_count", {29'd0, count}, 32'd0);
    check_eq("pop3_empty", {31'd0, empty}, 32'd1);

    do_req(1'b0, '0, 2, "pop_empty");
    check_eq("pop_empty_val", read_value, 32'd0);
    check_eq("pop_empty_unf", {31'd0, underflow}, 32'd1);
    check_eq("pop_empty_count", {29'd0, count}, 32'd0);
    pulse_clear();
    check_eq("clr_unf", {31'd0, underflow}, 32'd0);

    for (int k = 1; k <= 4; k++) begin
      do_req(1'b1, 32'hA000_0000 | k, 2, "fill");
    end
    check_eq("fill_full", {31'd0, full}, 32'd1);
    check_eq("fill_ovf", {31'd0, overflow}, 32'd0);
    do_req(1'b1, 32'hA000_0005, 2, "push_ovf");
    check_eq("ovf_flag", {31'd0, overflow}, 32'd1);
    check_eq("ovf_count", {29'd0, count}, 32'd4);
    do_req(1'b0, '0, 3, "pop_after_ovf");
    check_eq("pop_after_ovf_val", read_value, 32'hA000_0004);
    check_eq("pop_after_ovf_count", {29'd0, count}, 32'd3);
    pulse_clear();
    check_eq("clr_ovf", {31'd0, overflow}, 32'd0);

    // Trigger held high for 6 cycles must yield a single push.
    @(negedge clk);
    push        = 1'b1;
    write_value = 32'hBEEF_0006;
    trigger     = 1'b1;
    ndone       = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_out) ndone++;
    end
    trigger = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_out) ndone++;
    end
    check_eq("hold_ndone", ndone, 32'd1);
    check_eq("hold_count", {29'd0, count}, 32'd4);

    // Pop with a second rising edge landing while the pop is in RDW.
    @(negedge clk);
    push    = 1'b0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    check_eq("rdw_edge_done", {31'd0, done_out}, 32'd1);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_out) ndone++;
    end
    trigger = 1'b0;
    check_eq("rdw_edge_extra_done", ndone, 32'd0);
    check_eq("rdw_edge_count", {29'd0, count}, 32'd3);
    check_eq("rdw_edge_val", read_value, 32'hBEEF_0006);

    // Reset asserted while a pop sits in RDW.
    @(negedge clk);
    push    = 1'b0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_rdw_count", {29'd0, count}, 32'd0);
    check_eq("rst_rdw_rdval", read_value, 32'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_out) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_out) ndone++;
    end
    check_eq("rst_rdw_ndone", ndone, 32'd0);
    do_req(1'b1, 32'h5A5A_5A5A, 2, "post_rst_push");
    check_eq("post_rst_count", {29'd0, count}, 32'd1);
    do_req(1'b0, '0, 3, "post_rst_pop");
    check_eq("post_rst_val", read_value, 32'h5A5A_5A5A);
    check_eq("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/opstack_responder.md
Name: opstack_responder

Overview:
- Operand-stack memory that services the control FSM's push/pop requests over the push/trigger/write_value → read_value/done_out handshake.
- It is the responder end of that interface.
- Holds DEPTH 32-bit words in synchronous-read RAM and maintains the stack pointer.
- Reports occupancy and sticky overflow/underflow errors, and always completes a request so the control FSM can never hang.

Parameters:
DEPTH, 256, number of 32-bit stack entries; power of two, minimum 4
WIDTH, 32, data word width
CW, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
push  in  1  request type sampled with the trigger edge: 1 = push, 0 = pop
trigger  in  1  request strobe; a rising edge starts a request
write_value  in  WIDTH  push data, sampled with the trigger edge
read_value  out  WIDTH  popped data, registered; held until the next pop completes
done_out  out  1  one-cycle completion pulse
count  out  CW  current number of entries (equals the stack pointer)
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky; set by a push while full
underflow  out  1  sticky; set by a pop while empty
clear_err  in  1  synchronous clear of overflow and underflow

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (any time, including mid-request):
  - State IDLE, sp=0, read_value=0, done_out=0, overflow=0, underflow=0, trigger_q=0.
  - Any in-flight request is abandoned with no done_out.
  - RAM contents are not reset.
- Request detection:
  - start = trigger & ~trigger_q, where trigger_q is trigger registered every cycle.
  - A start is accepted only in IDLE. A start in any other state is ignored and not queued.
  - push and write_value are captured into request registers on the accepting edge.
- States: IDLE, WR, RD, RDW, RESP.
  - IDLE → WR on accepted start with push=1.
  - IDLE → RD on accepted start with push=0.
  - WR:
    - If sp < DEPTH: write RAM[sp] = captured data, sp ← sp+1.
    - Else: no write, sp unchanged, overflow ← 1.
    - → RESP.
  - RD:
    - If sp > 0: RAM read address = sp−1, sp ← sp−1, → RDW.
    - Else: underflow ← 1, read_value ← 0, → RESP (RAM not accessed).
  - RDW: read_value ← RAM read data (one-cycle RAM latency), → RESP.
  - RESP: done_out = 1 for exactly this cycle, → IDLE.
- Latency, counting from the clock edge that accepts the start:
  - Push: done_out is high in the 2nd cycle after acceptance.
  - Pop (non-empty): done_out is high in the 3rd cycle.
  - Pop (empty): done_out is high in the 2nd cycle.
- Back-to-back requests:
  - The initiator drops trigger while done_out is low and raises it again after seeing done_out.
  - A new rising edge in the cycle after RESP is accepted (state is already IDLE).
  - Minimum request spacing: 3 cycles for push, 4 cycles for pop.
- Outputs and flags:
  - read_value changes only on pop completion (RDW, or RD when empty). A push never alters it.
  - count, full and empty are combinational from sp.
  - sp is CW bits wide and never wraps: an overflow leaves sp at DEPTH, an underflow leaves sp at 0.
  - clear_err clears both sticky flags. If clear_err coincides with a new error in the same cycle, setting the flag wins.
- Error completion: requests that raise an error still produce done_out. The initiator checks the flags.

Decomposition:
- Package opstack_pkg:
  - State enum type (IDLE, WR, RD, RDW, RESP).
  - WORD_W=32 constant.
  - Request record typedef {push, data}.
- Sub-module opstack_ram:
  - Single-port synchronous RAM, DEPTH×WIDTH: we, addr, wdata, rdata, with rdata registered one cycle.
  - Written so that it infers block RAM.

Test Plan:
- Reset, then push 0x11111111, 0x22222222, 0x33333333 → each done_out 2 cycles after its trigger edge; count=3; empty=0.
- Then pop three times → read_value 0x33333333, 0x22222222, 0x11111111; done_out 3 cycles after each trigger edge; finally count=0, empty=1.
- Pop on empty stack → done_out after 2 cycles, read_value=0, underflow=1, count stays 0. Then clear_err → underflow=0.
- With DEPTH=4: push 5 words → full=1 after the 4th push; the 5th push still pulses done_out and sets overflow=1; count=4. A subsequent pop returns the 4th word, not the 5th.
- Hold trigger high for 6 cycles during a push → exactly one push and one done_out. A rising edge while in WR or RDW is ignored; count changes by 1 only.
- Assert rst_n=0 during RDW of a pop → done_out never pulses, count=0, read_value=0. A push after release works normally.
